// File: rtl/code_cov_pkg.sv
// Shared types and constants for the code_cov stimulus sequencer and its LFSR.
// Latency: n/a (package). Backpressure: n/a.
// Holds the state encoding, vector/LFSR widths and the Galois LFSR step function.
package code_cov_pkg;

    localparam int VEC_W     = 6;
    localparam int SWEEP_LEN = 64;
    localparam int LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_RST   = 3'd2,
        S_RAND  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    // Right-shifting Galois step: taps fold in whenever the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/code_cov_lfsr.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
// Latency: state updates one cycle after load/step. Backpressure: none, step is a plain enable.
module code_cov_lfsr
    import code_cov_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_OK = fix_seed(SEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_OK;
        end else if (load) begin
            state <= SEED_OK;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/code_cov_seq.sv
// Stimulus sequencer for code_cov: 64-vector sweep, DUT reset pulse, LFSR random run; CODE_COV_SEQ_SIG_EN adds an output signature.
// Latency: outputs registered, first vector one cycle after the start edge. Backpressure: none, self-timed; start ignored while busy, abort wins.
module code_cov_seq
    import code_cov_pkg::*;
#(
    parameter int              HOLD       = 2,
    parameter int              RST_CYCLES = 1,
    parameter int              RAND_LEN   = 20,
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec_o,
    output logic             vec_valid_o,
    output logic             dut_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       phase_o,
    input  logic             c_out,
    input  logic             p_out,
    input  logic             q_out,
    output logic [15:0]      sig_o
);

    localparam int              HW         = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [6:0]      SWEEP_LAST = 7'(SWEEP_LEN - 1);
    localparam logic [6:0]      RST_LAST   = 7'(RST_CYCLES - 1);
    localparam logic [6:0]      RAND_LAST  = 7'(RAND_LEN - 1);

    seq_state_e        state, state_nx;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic [6:0]        vec_cnt, vcnt_nx;
    logic              hold_end;
    logic              lfsr_load, lfsr_step;
    logic [LFSR_W-1:0] lfsr_q, lfsr_peek;
    logic [VEC_W-1:0]  vec_nx;

    code_cov_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_q)
    );

    assign hold_end = (hold_cnt == HOLD_LAST);
    assign phase_o  = state;

    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        vcnt_nx   = vec_cnt;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nx  = S_SWEEP;
                    hold_nx   = '0;
                    vcnt_nx   = '0;
                    lfsr_load = 1'b1;
                end
            end
            S_SWEEP: begin
                if (hold_end) begin
                    hold_nx = '0;
                    if (vec_cnt == SWEEP_LAST) begin
                        state_nx = S_RST;
                        vcnt_nx  = '0;
                    end else begin
                        vcnt_nx = vec_cnt + 7'd1;
                    end
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            // The vector counter doubles as the reset-pulse timer.
            S_RST: begin
                if (vec_cnt == RST_LAST) begin
                    state_nx = S_RAND;
                    vcnt_nx  = '0;
                    hold_nx  = '0;
                end else begin
                    vcnt_nx = vec_cnt + 7'd1;
                end
            end
            S_RAND: begin
                if (hold_end) begin
                    hold_nx   = '0;
                    lfsr_step = 1'b1;
                    if (vec_cnt == RAND_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        vcnt_nx = vec_cnt + 7'd1;
                    end
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (abort && (state != S_IDLE)) begin
            state_nx  = S_IDLE;
            lfsr_step = 1'b0;
        end

        // Random vectors come from the LFSR value that will be current next cycle.
        lfsr_peek = lfsr_step ? lfsr_next(lfsr_q) : lfsr_q;
        case (state_nx)
            S_SWEEP: vec_nx = vcnt_nx[VEC_W-1:0];
            S_RAND:  vec_nx = lfsr_peek[VEC_W-1:0];
            default: vec_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            vec_cnt     <= '0;
            vec_o       <= '0;
            vec_valid_o <= 1'b0;
            dut_rst_n_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            vec_cnt     <= vcnt_nx;
            vec_o       <= vec_nx;
            vec_valid_o <= (state_nx == S_SWEEP) || (state_nx == S_RAND);
            dut_rst_n_o <= (state_nx != S_RST);
            busy_o      <= (state_nx == S_SWEEP) || (state_nx == S_RST) || (state_nx == S_RAND);
            done_o      <= (state_nx == S_DONE);
        end
    end

`ifdef CODE_COV_SEQ_SIG_EN
    logic [15:0] sig_q;

    // Folds the DUT response in on the last hold cycle, once it has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (lfsr_load) begin
            sig_q <= '0;
        end else if (((state == S_SWEEP) || (state == S_RAND)) && hold_end) begin
            sig_q <= {sig_q[14:0], sig_q[15]} ^ {13'b0, c_out, p_out, q_out};
        end
    end

    assign sig_o = sig_q;
`else
    logic sig_unused;
    assign sig_unused = ^{c_out, p_out, q_out};
    assign sig_o      = '0;
`endif

endmodule

// File: tb/tb_code_cov_seq.sv
// Self-checking bench for code_cov_seq with default parameters.
// Expected per-cycle outputs and signature come from a table built from the sequencing rules.
module tb_code_cov_seq;

    localparam int HOLD       = 2;
    localparam int RST_CYCLES = 1;
    localparam int RAND_LEN   = 20;
    localparam int SPAN       = 1 + 64 * HOLD + RST_CYCLES + RAND_LEN * HOLD;

    localparam logic [12:0] RST_VAL  = {3'd0, 6'd0, 4'b0000};
    localparam logic [12:0] IDLE_VAL = {3'd0, 6'd0, 4'b0100};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  vec_o;
    logic        vec_valid_o, dut_rst_n_o, busy_o, done_o;
    logic [2:0]  phase_o;
    logic        c_out, p_out, q_out;
    logic [15:0] sig_o;

    int          mode = 0;
    int          checks = 0;
    int          errors = 0;

    logic [12:0] exp_tab [1:SPAN+1];
    logic [5:0]  valid_vecs [$];

    code_cov_seq #(
        .HOLD       (HOLD),
        .RST_CYCLES (RST_CYCLES),
        .RAND_LEN   (RAND_LEN),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .vec_o       (vec_o),
        .vec_valid_o (vec_valid_o),
        .dut_rst_n_o (dut_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .phase_o     (phase_o),
        .c_out       (c_out),
        .p_out       (p_out),
        .q_out       (q_out),
        .sig_o       (sig_o)
    );

    always #5 clk = ~clk;

    // Stand-in for the code_cov responses: all zero, q only, or a vector-dependent pattern.
    function automatic logic [2:0] stim_bits(input int m, input logic [5:0] v);
        case (m)
            0:       return 3'b000;
            1:       return 3'b001;
            default: return {v[5] & v[4], ^v[2:0], v[0]};
        endcase
    endfunction

    assign {c_out, p_out, q_out} = stim_bits(mode, vec_o);

    wire [12:0] obs = {phase_o, vec_o, vec_valid_o, dut_rst_n_o, busy_o, done_o};

    function automatic logic [15:0] galois(input logic [15:0] s);
        logic [15:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic build_model();
        int n;
        logic [15:0] s;
        logic [5:0] v;
        n = 1;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            valid_vecs.push_back(v);
            for (int h = 0; h < HOLD; h++) begin
                exp_tab[n] = {3'd1, v, 4'b1110};
                n++;
            end
        end
        for (int r = 0; r < RST_CYCLES; r++) begin
            exp_tab[n] = {3'd2, 6'd0, 4'b0010};
            n++;
        end
        s = 16'hACE1;
        for (int j = 0; j < RAND_LEN; j++) begin
            v = s[5:0];
            valid_vecs.push_back(v);
            for (int h = 0; h < HOLD; h++) begin
                exp_tab[n] = {3'd3, v, 4'b1110};
                n++;
            end
            s = galois(s);
        end
        exp_tab[n] = {3'd4, 6'd0, 4'b0101};
        exp_tab[n+1] = IDLE_VAL;
    endtask

    function automatic logic [15:0] exp_sig(input int m);
        logic [15:0] s;
        s = 16'h0000;
`ifdef CODE_COV_SEQ_SIG_EN
        foreach (valid_vecs[i]) s = {s[14:0], s[15]} ^ {13'b0, stim_bits(m, valid_vecs[i])};
`else
        if (m < 0) s = 16'h0000;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One sequence from a start pulse; abort_at/rst_at/extra_at are cycle offsets (0 = unused).
    task automatic run(input int m, input int abort_at, input int rst_at, input int extra_at,
                       output logic [15:0] sig_seen);
        logic [12:0] want;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= SPAN + 1; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("async_rst_c%0d", n), obs, RST_VAL);
                chk("async_rst_sig", sig_o, 16'h0000);
                start = 1'b0;
                break;
            end
            want = (abort_at != 0 && n > abort_at) ? IDLE_VAL : exp_tab[n];
            chk($sformatf("cycle_%0d", n), obs, want);
            if (n == 130 && abort_at == 0) chk("first_rand", vec_o, 6'h21);
            start = (n == extra_at);
            abort = (n == abort_at);
        end
        sig_seen = sig_o;
    endtask

    initial begin
        logic [15:0] s_a, s_b;
        int m;
        int gap;
        build_model();

        #1;
        chk("reset_state", obs, RST_VAL);
        chk("reset_sig", sig_o, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold", obs, RST_VAL);
        end
        rst_n = 1'b1;
        gap = $urandom_range(3, 10);
        repeat (gap) begin
            @(negedge clk);
            chk("idle_no_start", obs, IDLE_VAL);
        end

        m = $urandom_range(0, 2);
        run(m, 0, 0, $urandom_range(2, 120), s_a);
        chk("sig_run_a", s_a, exp_sig(m));

        run(0, 0, 0, 0, s_a);
        chk("sig_zero", s_a, 16'h0000);

        run(1, 50, 0, 0, s_a);

        run(1, 0, 0, 0, s_a);
        chk("sig_q1_first", s_a, exp_sig(1));
        run(1, 0, 0, 0, s_b);
        chk("sig_q1_second", s_b, exp_sig(1));
        chk("sig_repeat", s_b, s_a);
`ifdef CODE_COV_SEQ_SIG_EN
        chk("sig_nonzero", 32'(s_b != 16'h0000), 32'd1);
`endif

        run(2, 0, 140, 0, s_a);
        repeat (2) begin
            @(negedge clk);
            chk("rst_held", obs, RST_VAL);
        end
        rst_n = 1'b1;
        gap = $urandom_range(4, 12);
        repeat (gap) begin
            @(negedge clk);
            chk("idle_after_rst", obs, IDLE_VAL);
        end
        chk("sig_after_rst", sig_o, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
